// File: rtl/alu_operand_seq.sv
// Multi-beat ALU operand sequencer: processes a W = DW*NB bit operation
// one DW-bit beat per cycle, LSB first, with carry chained between beats.
module alu_operand_seq #(
  parameter int DW = 8,
  parameter int NB = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [DW*NB-1:0] a_in,
  input  logic [DW*NB-1:0] b_in,
  input  logic             ci_in,
  input  logic             z_in,
  output logic             busy,
  output logic             done,
  output logic [DW*NB-1:0] result,
  output logic             co,
  output logic             zf,
  output logic             nf,
  output logic             vf
);

  localparam int W  = DW * NB;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBC = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_EOR = 3'd6;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            c_q;
  logic [W-1:0]    a_q, b_q;
  logic [2:0]      op_q;
  logic            ci_q, z_q;

  logic            accept;
  logic            is_add, is_sub;
  logic [DW-1:0]   a_k, b_k;
  logic            cin0, cin_k;
  logic [DW:0]     beat_r;
  logic            co_nxt, zf_nxt, vf_nxt;

  // One beat of the operation; bit DW is the add-domain carry out.
  // Subtraction is a + ~b + c with c = ~borrow, so carry out = ~borrow out.
  function automatic logic [DW:0] beat_alu(input logic [2:0] o,
                                           input logic [DW-1:0] a,
                                           input logic [DW-1:0] b,
                                           input logic c);
    case (o)
      OP_ADD, OP_ADC: return {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, c};
      OP_SUB, OP_SBC: return {1'b0, a} + {1'b0, ~b} + {{DW{1'b0}}, c};
      OP_AND:         return {1'b0, a & b};
      OP_OR:          return {1'b0, a | b};
      OP_EOR:         return {1'b0, a ^ b};
      default:        return {1'b0, b};
    endcase
  endfunction

  // A start in the done cycle lands on IDLE but must still be ignored.
  assign accept = (state == IDLE) && start && !done;
  assign busy   = (state != IDLE);
  assign is_add = (op_q == OP_ADD) || (op_q == OP_ADC);
  assign is_sub = (op_q == OP_SUB) || (op_q == OP_SBC);

  // Next-state logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Beat operand selection and carry-in for the current beat.
  always_comb begin
    a_k = '0;
    b_k = '0;
    for (int k = 0; k < NB; k++) begin
      if (cnt == CW'(k)) begin
        a_k = a_q[k*DW +: DW];
        b_k = b_q[k*DW +: DW];
      end
    end
    case (op_q)
      OP_ADC:  cin0 = ci_q;
      OP_SUB:  cin0 = 1'b1;
      OP_SBC:  cin0 = ~ci_q;
      default: cin0 = 1'b0;
    endcase
    cin_k  = (cnt == '0) ? cin0 : c_q;
    beat_r = beat_alu(op_q, a_k, b_k, cin_k);
  end

  // Final flags, evaluated in DONE once every beat of result is written.
  always_comb begin
    co_nxt = ci_q;
    vf_nxt = 1'b0;
    if (is_add) begin
      co_nxt = c_q;
      vf_nxt = (a_q[W-1] == b_q[W-1]) && (result[W-1] != a_q[W-1]);
    end else if (is_sub) begin
      co_nxt = ~c_q;
      vf_nxt = (a_q[W-1] != b_q[W-1]) && (result[W-1] != a_q[W-1]);
    end
    zf_nxt = (result == '0) &&
             (((op_q == OP_ADC) || (op_q == OP_SBC)) ? z_q : 1'b1);
  end

  // Control state: FSM, beat counter, inter-beat carry, done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      c_q   <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == DONE);
      if (accept) begin
        cnt <= '0;
        c_q <= 1'b0;
      end else if (state == RUN) begin
        cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        c_q <= beat_r[DW];
      end
    end
  end

  // Operand capture on acceptance; isolates the operation from later input changes.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= a_in;
      b_q  <= b_in;
      op_q <= op;
      ci_q <= ci_in;
      z_q  <= z_in;
    end
  end

  // Result written beat by beat; flags registered when leaving DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result <= '0;
      co     <= 1'b0;
      zf     <= 1'b0;
      nf     <= 1'b0;
      vf     <= 1'b0;
    end else if (state == RUN) begin
      for (int k = 0; k < NB; k++) begin
        if (cnt == CW'(k)) result[k*DW +: DW] <= beat_r[DW-1:0];
      end
    end else if (state == DONE) begin
      co <= co_nxt;
      zf <= zf_nxt;
      nf <= result[W-1];
      vf <= vf_nxt;
    end
  end

endmodule
